// File: rtl/md_seq_ctrl_if.sv
// Handshake/bus bundle between the E-stage pipeline logic and the MD sequencer.
// The pipeline side (master) issues ops and mthi/mtlo writes; the unit side
// (slave) returns busy, stall and the architectural HI/LO values.
interface md_seq_ctrl_if;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, hi_we, lo_we, wdata, D_md_use,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, hi_we, lo_we, wdata, D_md_use,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer and HI/LO owner.
// An accepted op latches its operands, counts out a fixed latency and then
// commits the result to HI/LO. A divide by zero runs the full latency but
// leaves HI/LO untouched. stall holds a D-stage MD instruction until the
// unit is idle again.
module md_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    md_seq_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic              busy_q;

    logic [31:0]       md_hi_d;
    logic [31:0]       md_lo_d;
    logic              md_commit_d;
    logic [63:0]       prod_s;
    logic signed [31:0] sa_s;
    logic signed [31:0] sb_s;

    // Result datapath: computes the value to commit from the latched operands.
    always_comb begin
        md_hi_d     = hi_q;
        md_lo_d     = lo_q;
        md_commit_d = 1'b0;
        prod_s      = 64'd0;
        sa_s        = $signed(a_q);
        sb_s        = $signed(b_q);
        case (op_q)
            2'd0: begin
                // Low 64 bits of the sign-extended product equal the signed product.
                prod_s      = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
                md_hi_d     = prod_s[63:32];
                md_lo_d     = prod_s[31:0];
                md_commit_d = 1'b1;
            end
            2'd1: begin
                prod_s      = {32'd0, a_q} * {32'd0, b_q};
                md_hi_d     = prod_s[63:32];
                md_lo_d     = prod_s[31:0];
                md_commit_d = 1'b1;
            end
            2'd2: begin
                if (b_q == 32'd0) begin
                    md_commit_d = 1'b0;
                end else if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
                    // The only signed overflow case: the quotient wraps to itself.
                    md_lo_d     = 32'h8000_0000;
                    md_hi_d     = 32'd0;
                    md_commit_d = 1'b1;
                end else begin
                    md_lo_d     = sa_s / sb_s;
                    md_hi_d     = sa_s % sb_s;
                    md_commit_d = 1'b1;
                end
            end
            2'd3: begin
                if (b_q == 32'd0) begin
                    md_commit_d = 1'b0;
                end else begin
                    md_lo_d     = a_q / b_q;
                    md_hi_d     = a_q % b_q;
                    md_commit_d = 1'b1;
                end
            end
            default: begin
                md_commit_d = 1'b0;
            end
        endcase
    end

    // Sequencer FSM: op acceptance, latency countdown, HI/LO commit and mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.md_op;
                        a_q     <= bus.rs_val;
                        b_q     <= bus.rt_val;
                        cnt_q   <= bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        if (bus.hi_we) begin
                            hi_q <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_q <= bus.wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (md_commit_d) begin
                            hi_q <= md_hi_d;
                            lo_q <= md_lo_d;
                        end
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    // Covers the issue cycle too, so a dependent mfhi/mflo waits for the commit.
    assign bus.stall = bus.D_md_use & (bus.start | busy_q);

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl: directed scenarios followed by random
// traffic, all compared against a cycles-remaining reference model.
module tb_md_seq_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    md_seq_ctrl_if bus();

    md_seq_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_ok;
    int          m_rem;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic hw, input logic lw, input logic [31:0] wd);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, up;
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; p_ok = 1'b0;
        end else if (m_rem == 0) begin
            if (st) begin
                m_rem = op[1] ? DIV_N : MULT_N;
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
                ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
                p_ok = 1'b1;
                p_hi = 32'd0; p_lo = 32'd0;
                case (op)
                    2'd0: begin q = sa * sb; p_hi = 32'(q >>> 32); p_lo = 32'(q); end
                    2'd1: begin up = ua * ub; p_hi = 32'(up >> 32); p_lo = 32'(up); end
                    2'd2: begin
                        if (b == 32'd0) p_ok = 1'b0;
                        else begin q = sa / sb; r = sa - q * sb; p_lo = 32'(q); p_hi = 32'(r); end
                    end
                    default: begin
                        if (b == 32'd0) p_ok = 1'b0;
                        else begin uq = ua / ub; ur = ua - uq * ub; p_lo = 32'(uq); p_hi = 32'(ur); end
                    end
                endcase
            end else begin
                if (hw) m_hi = wd;
                if (lw) m_lo = wd;
            end
        end else begin
            m_rem--;
            if (m_rem == 0 && p_ok) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end
    endtask

    // One clock cycle: drive inputs, check stall, clock, advance model, check state.
    task automatic step(input logic rst, input logic st, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic hw, input logic lw, input logic [31:0] wd,
                        input logic use_d);
        reset        = rst;
        bus.start    = st;
        bus.md_op    = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        bus.hi_we    = hw;
        bus.lo_we    = lw;
        bus.wdata    = wd;
        bus.D_md_use = use_d;
        #1;
        check_val("stall", 64'(bus.stall), 64'(use_d & (st | (m_rem > 0))));
        @(posedge clk);
        model_edge(rst, st, op, a, b, hw, lw, wd);
        #1;
        check_val("busy", 64'(bus.busy), 64'(m_rem > 0));
        check_val("hi", 64'(bus.hi), 64'(m_hi));
        check_val("lo", 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0, $urandom, use_d);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
        step(1'b0, 1'b1, op, a, b, 1'b0, 1'b0, 32'd0, use_d);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0; p_ok = 1'b0; m_rem = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.md_op = 2'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'd0; bus.D_md_use = 1'b0;
        @(posedge clk);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        check_val("rst_hi", 64'(bus.hi), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);

        // mthi / mtlo
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        check_val("mthi", 64'(bus.hi), 64'h1234_5678);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h9ABC_DEF0, 1'b0);
        check_val("mtlo", 64'(bus.lo), 64'h9ABC_DEF0);

        // mult / multu
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(MULT_N, 1'b0);
        check_val("mult", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(2'd1, 32'hFFFF_FFFE, 32'd3, 1'b0); idle(MULT_N, 1'b0);
        check_val("multu", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFA);

        // div / divu, stall held throughout the divu
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(DIV_N, 1'b0);
        check_val("div", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(2'd3, 32'd7, 32'd2, 1'b1); idle(DIV_N, 1'b1);
        check_val("divu", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
        check_val("stall_end", 64'(bus.stall), 64'd0);

        // divide by zero keeps HI/LO
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd6, 1'b0);
        issue(2'd3, 32'd7, 32'd0, 1'b0); idle(DIV_N, 1'b0);
        check_val("divz", {bus.hi, bus.lo}, 64'h0000_0005_0000_0006);

        // start and mthi/mtlo mid-run are ignored
        issue(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0); idle(2, 1'b0);
        step(1'b0, 1'b1, 2'd3, 32'd9, 32'd1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        idle(2, 1'b0);
        check_val("midrun", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
        check_val("midrun_busy", 64'(bus.busy), 64'd0);

        // signed overflow
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle(DIV_N, 1'b0);
        check_val("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        // reset mid-divide, then a fresh mult
        issue(2'd2, 32'd100, 32'd7, 1'b0); idle(2, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        check_val("rst_mid", {31'd0, bus.busy, bus.hi, bus.lo}, 65'd0);
        issue(2'd0, 32'd3, 32'd4, 1'b0); idle(MULT_N, 1'b0);
        check_val("mult_after_rst", {bus.hi, bus.lo}, 64'd12);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0), 2'($urandom),
                 a, b, 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
Multi-cycle multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline. It accepts an MD op issued from the E stage, counts out the fixed operation latency, and commits the result to HI/LO. It also generates the stall request that freezes the PC/FD registers and bubbles the DE register while a D-stage instruction needs the unit.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  E-stage MD op issue strobe, one cycle
md_op  input  2  0 mult, 1 multu, 2 div, 3 divu; sampled with start
rs_val  input  32  operand A / dividend (forwarded E-stage value)
rt_val  input  32  operand B / divisor
hi_we  input  1  mthi write enable (E stage)
lo_we  input  1  mtlo write enable (E stage)
wdata  input  32  mthi/mtlo data
D_md_use  input  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in progress
stall  output  1  pipeline stall request to hazard logic
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (synchronous, active-high): state IDLE, counter 0, latched operands and op 0, hi=0, lo=0, busy=0. Reset mid-operation aborts the op and leaves HI/LO=0.
- States: IDLE, RUN. busy is registered: busy = (state==RUN).
- IDLE + start at cycle t: latch rs_val, rt_val, md_op; load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); go to RUN. busy=1 for cycles t+1..t+N.
- RUN: decrement the counter each cycle. On the edge where the counter==1: commit the result, clear the counter, and go to IDLE. New HI/LO are visible in cycle t+N+1, and busy=0 in that cycle.
- Results:
  - mult: {hi,lo} = signed 64-bit rs*rt. multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - divu: unsigned lo = quotient, hi = remainder.
- Divide by zero (latched rt==0, op 2/3): runs the full DIV_CYCLES, then HI/LO stay unchanged.
- Signed div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo: in IDLE with start=0, hi<=wdata / lo<=wdata at the next edge. hi_we and lo_we may both be set in the same cycle.
- Ignored inputs:
  - hi_we/lo_we while busy=1 or start=1.
  - start while in RUN. The state, counter and latched operands do not change.
- stall = D_md_use & (start | busy), combinational. It covers the issue cycle, so a dependent mfhi is held until the result is committed. mfhi/mflo read hi/lo directly with no bypass.
- Operands are sampled only on the start cycle. Later changes to rs_val/rt_val have no effect.
- Back-to-back: start is accepted in the first cycle after busy falls. That cycle is IDLE, so a new start is legal there.

Test Plan:
- reset, then mthi 0x12345678 and mtlo 0x9ABCDEF0 in consecutive idle cycles -> hi=0x12345678, lo=0x9ABCDEF0 one cycle after each write; busy stays 0.
- mult rs=0xFFFFFFFE (-2), rt=3 at cycle t -> busy high t+1..t+5; at t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 -> lo=3, hi=1.
- D_md_use=1 held from cycle t while start at t -> stall=1 for t..t+10, 0 at t+11. D_md_use=0 during busy -> stall=0.
- These are the "ignored" cases:
  - divu rt=0 from prior hi=5, lo=6 -> after 10 cycles hi=5, lo=6.
  - start and hi_we asserted mid-RUN -> the op completes at the original cycle with the original result, and HI is not overwritten by wdata.
- reset pulsed at cycle 3 of a div -> next cycle busy=0, hi=lo=0. A fresh mult then completes normally in 5 cycles.
